regfile_write_arbiter: RTL and testbench

//  Shares the single register-file write port (WRT_ENA/ADDRS_RD/WRT_DATA) between two

---
 rtl/regfile_write_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single register-file write port between two writeback
// requesters: A (ALU result) and B (memory load). Each requester owns a
// one-entry holding buffer filled through a valid/ready handshake. One
// buffered entry is granted per cycle:
//   - round-robin between A and B when the buffers target different registers
//   - the older entry first when both target the same register, so two writes
//     to one register always land in program order.
// Writes to R15 (all-ones address) are steered to the PC load path instead of
// the register-file port. A per-register pending mask is exported so decode
// can detect hazards against writes still sitting in the buffers.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_a_valid    requester A has a write
//   i_a_rd       A destination register
//   i_a_data     A write data
//   o_a_ready    A is accepted at the next edge when i_a_valid is also high
//   i_b_valid    requester B has a write
//   i_b_rd       B destination register
//   i_b_data     B write data
//   o_b_ready    B is accepted at the next edge when i_b_valid is also high
//   o_wrt_ena    register-file write enable
//   o_addrs_rd   register-file write address
//   o_wrt_data   register-file write data
//   o_pc_load    one-cycle pulse: an R15 write was granted
//   o_pc_data    value for the PC while o_pc_load is high
//   o_busy       bit i set while a buffered write to register i is pending
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_a_valid,
  input  logic [ADDR_W-1:0]        i_a_rd,
  input  logic [DATA_W-1:0]        i_a_data,
  output logic                     o_a_ready,
  input  logic                     i_b_valid,
  input  logic [ADDR_W-1:0]        i_b_rd,
  input  logic [DATA_W-1:0]        i_b_data,
  output logic                     o_b_ready,
  output logic                     o_wrt_ena,
  output logic [ADDR_W-1:0]        o_addrs_rd,
  output logic [DATA_W-1:0]        o_wrt_data,
  output logic                     o_pc_load,
  output logic [DATA_W-1:0]        o_pc_data,
  output logic [(1<<ADDR_W)-1:0]   o_busy
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_REG = '1;

  // Holding buffers
  logic              r_a_vld;
  logic [ADDR_W-1:0] r_a_rd;
  logic [DATA_W-1:0] r_a_data;
  logic              r_b_vld;
  logic [ADDR_W-1:0] r_b_rd;
  logic [DATA_W-1:0] r_b_data;

  // r_prio: 0 = A wins the next different-register contention, 1 = B wins.
  // r_b_older: 1 when the entry in buffer B was accepted before the one in A.
  logic r_prio;
  logic r_b_older;

  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_load_a;
  logic              w_load_b;
  logic              w_a_stays;
  logic              w_b_stays;
  logic              w_sel_vld;
  logic [ADDR_W-1:0] w_sel_rd;
  logic [DATA_W-1:0] w_sel_data;
  logic [NREG-1:0]   w_busy;

  // Grant selection. Reset gates every grant so nothing reaches the register
  // file or the PC while reset is asserted, even if the buffers still hold
  // entries from before the reset edge.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (i_rst_n) begin
      if (r_a_vld && !r_b_vld) begin
        w_grant_a = 1'b1;
      end else if (!r_a_vld && r_b_vld) begin
        w_grant_b = 1'b1;
      end else if (r_a_vld && r_b_vld) begin
        if (r_a_rd == r_b_rd) begin
          // Same destination: program order beats fairness.
          if (r_b_older) begin
            w_grant_b = 1'b1;
          end else begin
            w_grant_a = 1'b1;
          end
        end else if (r_prio) begin
          w_grant_b = 1'b1;
        end else begin
          w_grant_a = 1'b1;
        end
      end
    end
  end

  // A buffer can be refilled in the same cycle its entry is granted, which is
  // what sustains one write per cycle per requester.
  always_comb begin
    o_a_ready = i_rst_n && (!r_a_vld || w_grant_a);
    o_b_ready = i_rst_n && (!r_b_vld || w_grant_b);
    w_load_a  = i_a_valid && o_a_ready;
    w_load_b  = i_b_valid && o_b_ready;
    w_a_stays = r_a_vld && !w_grant_a;
    w_b_stays = r_b_vld && !w_grant_b;
  end

  // Route the granted entry either to the register-file port or, for R15, to
  // the PC load path. Unused outputs are forced to zero when idle.
  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_rd   = '0;
    w_sel_data = '0;
    if (w_grant_a) begin
      w_sel_vld  = 1'b1;
      w_sel_rd   = r_a_rd;
      w_sel_data = r_a_data;
    end else if (w_grant_b) begin
      w_sel_vld  = 1'b1;
      w_sel_rd   = r_b_rd;
      w_sel_data = r_b_data;
    end

    o_wrt_ena  = w_sel_vld && (w_sel_rd != PC_REG);
    o_pc_load  = w_sel_vld && (w_sel_rd == PC_REG);
    o_addrs_rd = o_wrt_ena ? w_sel_rd   : '0;
    o_wrt_data = o_wrt_ena ? w_sel_data : '0;
    o_pc_data  = o_pc_load ? w_sel_data : '0;
  end

  // Pending mask: one-hot decode of each valid buffer's destination.
  always_comb begin
    w_busy = (NREG'(r_a_vld) << r_a_rd) | (NREG'(r_b_vld) << r_b_rd);
    o_busy = i_rst_n ? w_busy : '0;
  end

  // Buffer A: load on handshake, otherwise drain when granted.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a_vld  <= 1'b0;
      r_a_rd   <= '0;
      r_a_data <= '0;
    end else if (w_load_a) begin
      r_a_vld  <= 1'b1;
      r_a_rd   <= i_a_rd;
      r_a_data <= i_a_data;
    end else if (w_grant_a) begin
      r_a_vld  <= 1'b0;
    end
  end

  // Buffer B: load on handshake, otherwise drain when granted.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_b_vld  <= 1'b0;
      r_b_rd   <= '0;
      r_b_data <= '0;
    end else if (w_load_b) begin
      r_b_vld  <= 1'b1;
      r_b_rd   <= i_b_rd;
      r_b_data <= i_b_data;
    end else if (w_grant_b) begin
      r_b_vld  <= 1'b0;
    end
  end

  // Round-robin pointer flips away from whichever side was just served.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prio <= 1'b0;
    end else if (w_grant_a) begin
      r_prio <= 1'b1;
    end else if (w_grant_b) begin
      r_prio <= 1'b0;
    end
  end

  // Age tracking. An entry that stays in its buffer while the other side
  // loads is older than the newcomer. When both load on the same edge A is
  // treated as older. When only one buffer ends up occupied the flag is
  // irrelevant and simply holds.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_b_older <= 1'b0;
    end else if (w_load_a && w_load_b) begin
      r_b_older <= 1'b0;
    end else if (w_load_a && w_b_stays) begin
      r_b_older <= 1'b1;
    end else if (w_load_b && w_a_stays) begin
      r_b_older <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Bench for regfile_write_arbiter. A table of per-cycle vectors covers reset,
// single writes, contention, same-register ordering, the R15/PC path and a
// mid-operation reset. A streaming section keeps both requesters busy and
// checks the sequence of register-file writes against a queue of expected
// writes filled as each item is presented.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NREG   = 16;

  logic              clk = 1'b0;
  logic              rstN;
  logic              aValid;
  logic [ADDR_W-1:0] aRd;
  logic [DATA_W-1:0] aData;
  logic              aReady;
  logic              bValid;
  logic [ADDR_W-1:0] bRd;
  logic [DATA_W-1:0] bData;
  logic              bReady;
  logic              wrtEna;
  logic [ADDR_W-1:0] addrsRd;
  logic [DATA_W-1:0] wrtData;
  logic              pcLoad;
  logic [DATA_W-1:0] pcData;
  logic [NREG-1:0]   busy;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_a_valid  (aValid),
    .i_a_rd     (aRd),
    .i_a_data   (aData),
    .o_a_ready  (aReady),
    .i_b_valid  (bValid),
    .i_b_rd     (bRd),
    .i_b_data   (bData),
    .o_b_ready  (bReady),
    .o_wrt_ena  (wrtEna),
    .o_addrs_rd (addrsRd),
    .o_wrt_data (wrtData),
    .o_pc_load  (pcLoad),
    .o_pc_data  (pcData),
    .o_busy     (busy)
  );

  typedef struct {
    logic        rst;
    logic        aV;
    logic [3:0]  aRd;
    logic [31:0] aD;
    logic        bV;
    logic [3:0]  bRd;
    logic [31:0] bD;
    logic        expAReady;
    logic        expBReady;
    logic        expWen;
    logic [3:0]  expAddr;
    logic [31:0] expData;
    logic        expPc;
    logic [31:0] expPcData;
    logic [15:0] expBusy;
  } vec_t;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
  } wr_t;

  vec_t        vecs[$];
  wr_t         sbQ[$];
  logic [31:0] regModel [NREG];
  int          checks = 0;
  int          errors = 0;

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic addVec(
    input logic rst,
    input logic aV, input logic [3:0] aRdI, input logic [31:0] aD,
    input logic bV, input logic [3:0] bRdI, input logic [31:0] bD,
    input logic eAR, input logic eBR, input logic eWen,
    input logic [3:0] eAddr, input logic [31:0] eData,
    input logic ePc, input logic [31:0] ePcData, input logic [15:0] eBusy);
    vec_t v;
    v.rst = rst; v.aV = aV; v.aRd = aRdI; v.aD = aD;
    v.bV = bV; v.bRd = bRdI; v.bD = bD;
    v.expAReady = eAR; v.expBReady = eBR; v.expWen = eWen;
    v.expAddr = eAddr; v.expData = eData;
    v.expPc = ePc; v.expPcData = ePcData; v.expBusy = eBusy;
    vecs.push_back(v);
  endtask

  // Drive one vector's inputs onto the DUT.
  task automatic applyStimulus(input vec_t v);
    rstN   = v.rst;
    aValid = v.aV;
    aRd    = v.aRd;
    aData  = v.aD;
    bValid = v.bV;
    bRd    = v.bRd;
    bData  = v.bD;
  endtask

  initial begin
    int ia;
    int ib;
    int pushedA;
    int pushedB;
    int streamWrites;
    logic accA;
    logic accB;
    wr_t exp;

    for (int r = 0; r < NREG; r++) regModel[r] = '0;

    //     rst aV rd  aData          bV rd  bData     aR bR wen addr data           pc pcData    busy
    addVec(0,  1, 3,  32'h1,         1, 4,  32'h2,    0, 0, 0,  0,   32'h0,         0, 32'h0,    16'h0000);
    addVec(0,  1, 3,  32'h1,         1, 4,  32'h2,    0, 0, 0,  0,   32'h0,         0, 32'h0,    16'h0000);
    addVec(1,  0, 0,  32'h0,         0, 0,  32'h0,    1, 1, 0,  0,   32'h0,         0, 32'h0,    16'h0000);
    addVec(1,  1, 3,  32'h12345678,  0, 0,  32'h0,    1, 1, 0,  0,   32'h0,         0, 32'h0,    16'h0000);
    addVec(1,  0, 0,  32'h0,         0, 0,  32'h0,    1, 1, 1,  3,   32'h12345678,  0, 32'h0,    16'h0008);
    addVec(1,  0, 0,  32'h0,         0, 0,  32'h0,    1, 1, 0,  0,   32'h0,         0, 32'h0,    16'h0000);
    addVec(0,  0, 0,  32'h0,         0, 0,  32'h0,    0, 0, 0,  0,   32'h0,         0, 32'h0,    16'h0000);
    addVec(1,  1, 1,  32'h11,        1, 2,  32'h22,   1, 1, 0,  0,   32'h0,         0, 32'h0,    16'h0000);
    addVec(1,  0, 0,  32'h0,         0, 0,  32'h0,    1, 0, 1,  1,   32'h11,        0, 32'h0,    16'h0006);
    addVec(1,  0, 0,  32'h0,         0, 0,  32'h0,    1, 1, 1,  2,   32'h22,        0, 32'h0,    16'h0004);
    addVec(1,  0, 0,  32'h0,         0, 0,  32'h0,    1, 1, 0,  0,   32'h0,         0, 32'h0,    16'h0000);
    addVec(1,  1, 15, 32'h100,       0, 0,  32'h0,    1, 1, 0,  0,   32'h0,         0, 32'h0,    16'h0000);
    addVec(1,  0, 0,  32'h0,         0, 0,  32'h0,    1, 1, 0,  0,   32'h0,         1, 32'h100,  16'h8000);
    addVec(1,  0, 0,  32'h0,         0, 0,  32'h0,    1, 1, 0,  0,   32'h0,         0, 32'h0,    16'h0000);
    addVec(1,  1, 7,  32'h77,        1, 8,  32'h88,   1, 1, 0,  0,   32'h0,         0, 32'h0,    16'h0000);
    addVec(0,  0, 0,  32'h0,         0, 0,  32'h0,    0, 0, 0,  0,   32'h0,         0, 32'h0,    16'h0000);
    addVec(1,  0, 0,  32'h0,         0, 0,  32'h0,    1, 1, 0,  0,   32'h0,         0, 32'h0,    16'h0000);
    addVec(1,  1, 9,  32'h99,        0, 0,  32'h0,    1, 1, 0,  0,   32'h0,         0, 32'h0,    16'h0000);
    addVec(1,  0, 0,  32'h0,         0, 0,  32'h0,    1, 1, 1,  9,   32'h99,        0, 32'h0,    16'h0200);
    addVec(1,  1, 5,  32'hA,         1, 5,  32'hB,    1, 1, 0,  0,   32'h0,         0, 32'h0,    16'h0000);
    addVec(1,  0, 0,  32'h0,         0, 0,  32'h0,    1, 0, 1,  5,   32'hA,         0, 32'h0,    16'h0020);
    addVec(1,  0, 0,  32'h0,         0, 0,  32'h0,    1, 1, 1,  5,   32'hB,         0, 32'h0,    16'h0020);
    addVec(1,  0, 0,  32'h0,         1, 5,  32'hB,    1, 1, 0,  0,   32'h0,         0, 32'h0,    16'h0000);
    addVec(1,  1, 5,  32'hA,         0, 0,  32'h0,    1, 1, 1,  5,   32'hB,         0, 32'h0,    16'h0020);
    addVec(1,  0, 0,  32'h0,         0, 0,  32'h0,    1, 1, 1,  5,   32'hA,         0, 32'h0,    16'h0020);
    addVec(1,  0, 0,  32'h0,         0, 0,  32'h0,    1, 1, 0,  0,   32'h0,         0, 32'h0,    16'h0000);

    // Table section: inputs change just after the rising edge, outputs are
    // sampled on the falling edge of the same cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d.aReady", i),  32'(aReady),  32'(vecs[i].expAReady));
      checkOutput($sformatf("v%0d.bReady", i),  32'(bReady),  32'(vecs[i].expBReady));
      checkOutput($sformatf("v%0d.wrtEna", i),  32'(wrtEna),  32'(vecs[i].expWen));
      checkOutput($sformatf("v%0d.addrsRd", i), 32'(addrsRd), 32'(vecs[i].expAddr));
      checkOutput($sformatf("v%0d.wrtData", i), wrtData,      vecs[i].expData);
      checkOutput($sformatf("v%0d.pcLoad", i),  32'(pcLoad),  32'(vecs[i].expPc));
      checkOutput($sformatf("v%0d.pcData", i),  pcData,       vecs[i].expPcData);
      checkOutput($sformatf("v%0d.busy", i),    32'(busy),    32'(vecs[i].expBusy));
      if (wrtEna === 1'b1) regModel[addrsRd] = wrtData;
      @(posedge clk);
      #1;
    end

    // The later write to R5 must be the one left in the register file.
    checkOutput("readback.R5", regModel[5], 32'hA);

    // Streaming section: reset so the pointer starts at A, then keep both
    // requesters busy for four items each; writes must alternate A,B,A,B.
    rstN   = 1'b0;
    aValid = 1'b0;
    bValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;

    ia = 0;
    ib = 0;
    pushedA = -1;
    pushedB = -1;
    streamWrites = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (ia < 4) begin
        aValid = 1'b1;
        aRd    = 4'(1 + ia);
        aData  = 32'hA000_0000 + 32'(ia);
        if (pushedA != ia) begin
          sbQ.push_back('{rd: 4'(1 + ia), data: 32'hA000_0000 + 32'(ia)});
          pushedA = ia;
        end
      end else begin
        aValid = 1'b0;
      end
      if (ib < 4) begin
        bValid = 1'b1;
        bRd    = 4'(8 + ib);
        bData  = 32'hB000_0000 + 32'(ib);
        if (pushedB != ib) begin
          sbQ.push_back('{rd: 4'(8 + ib), data: 32'hB000_0000 + 32'(ib)});
          pushedB = ib;
        end
      end else begin
        bValid = 1'b0;
      end

      @(negedge clk);
      if (wrtEna === 1'b1) begin
        streamWrites++;
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL stream.unexpected actual=R%0d:0x%0h expected=no write", addrsRd, wrtData);
        end else begin
          exp = sbQ.pop_front();
          checkOutput($sformatf("stream%0d.addr", streamWrites), 32'(addrsRd), 32'(exp.rd));
          checkOutput($sformatf("stream%0d.data", streamWrites), wrtData, exp.data);
        end
      end
      accA = aValid && aReady;
      accB = bValid && bReady;
      @(posedge clk);
      #1;
      if (accA) ia++;
      if (accB) ib++;
      if (ia == 4 && ib == 4 && sbQ.size() == 0) break;
    end
    aValid = 1'b0;
    bValid = 1'b0;

    checkOutput("stream.writeCount", 32'(streamWrites), 32'd8);
    checkOutput("stream.pending", 32'(sbQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
